// File: rtl/branch_seq_if.sv
// Decode-side handshake between the ID stage and the branch resolution sequencer,
// including the shared comparator option/result pair and the PC redirect.
interface branch_seq_if;
    logic        br_req;
    logic [2:0]  br_op;
    logic [31:0] br_target;
    logic        rs_ready;
    logic        rt_ready;
    logic        cmp_res;
    logic [2:0]  cmp_option;
    logic        stall;
    logic        br_done;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output br_req, br_op, br_target, rs_ready, rt_ready, cmp_res,
        input  cmp_option, stall, br_done, redirect, redirect_pc
    );

    modport slave (
        input  br_req, br_op, br_target, rs_ready, rt_ready, cmp_res,
        output cmp_option, stall, br_done, redirect, redirect_pc
    );
endinterface

// File: rtl/branch_seq.sv
// Branch resolution sequencer: waits for forwarded operands, drives the shared
// comparator, and issues a one-cycle redirect plus saturating branch statistics.
module branch_seq #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_seq_if.slave      br,
    input  logic             clr_stat,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic             illegal,
    output logic             timeout
);
    localparam int                WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [2:0]        OP_NEVER  = 3'b000;
    localparam logic [2:0]        OP_EQ     = 3'b001;
    localparam logic [2:0]        OP_ALWAYS = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_in, op_next;
    logic [31:0]       target_q;
    logic [WAIT_W-1:0] wait_q;
    logic              taken_q;
    logic              reserved, accept, sample, expire;

    // Reserved codes are remapped to "never" so they cannot reach the comparator.
    assign reserved = !(br.br_op inside {OP_NEVER, OP_EQ, OP_ALWAYS});
    assign op_in    = reserved ? OP_NEVER : br.br_op;
    assign op_next  = accept ? op_in : op_q;

    // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer latches.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sample  = 1'b0;
        expire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (br.br_req) begin
                    accept  = 1'b1;
                    state_d = (op_in == OP_EQ && !(br.rs_ready && br.rt_ready)) ? S_WAIT : S_EVAL;
                end
            end
            S_WAIT: begin
                if (!br.br_req) begin
                    state_d = S_IDLE;
                end else if (br.rs_ready && br.rt_ready) begin
                    state_d = S_EVAL;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    expire  = 1'b1;
                end
            end
            S_EVAL: begin
                if (!br.br_req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    sample  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= OP_NEVER;
            target_q       <= '0;
            wait_q         <= '0;
            taken_q        <= 1'b0;
            br.cmp_option  <= OP_NEVER;
            br.redirect_pc <= '0;
        end else begin
            state_q       <= state_d;
            br.cmp_option <= (state_d == S_EVAL) ? op_next : OP_NEVER;
            if (accept) begin
                op_q     <= op_in;
                target_q <= br.br_target;
            end
            if (accept) begin
                wait_q <= '0;
            end else if (state_q == S_WAIT && state_d == S_WAIT) begin
                wait_q <= wait_q + WAIT_W'(1);
            end
            if (sample) begin
                taken_q <= br.cmp_res;
            end else if (expire) begin
                taken_q <= 1'b0;
            end
            // Loaded on entry to DONE so the PC sees the target alongside redirect.
            if (sample && br.cmp_res) begin
                br.redirect_pc <= target_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
            total_cnt <= '0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
        end else if (clr_stat) begin
            taken_cnt <= '0;
            total_cnt <= '0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (state_q == S_DONE) begin
                if (total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
                if (taken_q && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if (accept && reserved) illegal <= 1'b1;
            if (expire) timeout <= 1'b1;
        end
    end

    assign br.br_done  = (state_q == S_DONE);
    assign br.redirect = (state_q == S_DONE) && taken_q;
    assign br.stall    = rst_n && br.br_req && (state_q != S_DONE);
endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq with a behavioural comparator; CNT_W=2 and
// MAX_WAIT=4 so saturation and timeout are reachable in a few cycles.
module tb_branch_seq;
    logic       clk;
    logic       rst_n;
    logic       clr_stat;
    logic [1:0] taken_cnt;
    logic [1:0] total_cnt;
    logic       illegal;
    logic       timeout;
    logic       eq_val;
    int         n_checks;
    int         n_errors;

    branch_seq_if bif ();

    branch_seq #(.CNT_W(2), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .br        (bif.slave),
        .clr_stat  (clr_stat),
        .taken_cnt (taken_cnt),
        .total_cnt (total_cnt),
        .illegal   (illegal),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared comparator: never / equal / always, zero for anything else.
    always_comb begin
        case (bif.cmp_option)
            3'b001:  bif.cmp_res = eq_val;
            3'b111:  bif.cmp_res = 1'b1;
            default: bif.cmp_res = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic req, input logic [2:0] op, input logic [31:0] tgt,
                         input logic rs, input logic rt);
        bif.br_req    = req;
        bif.br_op     = op;
        bif.br_target = tgt;
        bif.rs_ready  = rs;
        bif.rt_ready  = rt;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clr_stat = 1'b0;
        eq_val   = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        tick();
        smp();
        check("rst_cmp_option", bif.cmp_option, 3'b000);
        check("rst_br_done", bif.br_done, 1'b0);
        check("rst_redirect_pc", bif.redirect_pc, 32'h0);
        check("rst_total_cnt", total_cnt, 2'd0);
        check("rst_flags", {illegal, timeout}, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();

        // Taken equal-branch, operands ready.
        drive(1'b1, 3'b001, 32'h0000_3010, 1'b1, 1'b1);
        eq_val = 1'b1;
        smp();
        check("t1_c0_stall", bif.stall, 1'b1);
        check("t1_c0_cmp_option", bif.cmp_option, 3'b000);
        tick();
        smp();
        check("t1_c1_cmp_option", bif.cmp_option, 3'b001);
        check("t1_c1_stall", bif.stall, 1'b1);
        check("t1_c1_br_done", bif.br_done, 1'b0);
        tick();
        smp();
        check("t1_c2_br_done", bif.br_done, 1'b1);
        check("t1_c2_redirect", bif.redirect, 1'b1);
        check("t1_c2_redirect_pc", bif.redirect_pc, 32'h0000_3010);
        check("t1_c2_stall", bif.stall, 1'b0);
        tick();
        drive(1'b0, 3'b000, 32'h0, 1'b1, 1'b1);
        smp();
        check("t1_total_cnt", total_cnt, 2'd1);
        check("t1_taken_cnt", taken_cnt, 2'd1);
        check("t1_idle_br_done", bif.br_done, 1'b0);

        // Not-taken equal-branch with rt late by three cycles.
        tick();
        drive(1'b1, 3'b001, 32'h0000_4000, 1'b1, 1'b0);
        eq_val = 1'b0;
        smp();
        check("t2_c0_stall", bif.stall, 1'b1);
        tick();
        smp();
        check("t2_c1_cmp_option", bif.cmp_option, 3'b000);
        tick();
        smp();
        check("t2_c2_cmp_option", bif.cmp_option, 3'b000);
        tick();
        bif.rt_ready = 1'b1;
        smp();
        check("t2_c3_cmp_option", bif.cmp_option, 3'b000);
        tick();
        smp();
        check("t2_c4_cmp_option", bif.cmp_option, 3'b001);
        check("t2_c4_br_done", bif.br_done, 1'b0);
        tick();
        smp();
        check("t2_c5_br_done", bif.br_done, 1'b1);
        check("t2_c5_redirect", bif.redirect, 1'b0);
        check("t2_c5_redirect_pc", bif.redirect_pc, 32'h0000_3010);
        tick();
        drive(1'b0, 3'b000, 32'h0, 1'b1, 1'b1);
        smp();
        check("t2_total_cnt", total_cnt, 2'd2);
        check("t2_taken_cnt", taken_cnt, 2'd1);

        // Reserved op 011: flagged, resolved not-taken.
        tick();
        drive(1'b1, 3'b011, 32'h0000_6000, 1'b1, 1'b1);
        smp();
        check("t3_c0_illegal", illegal, 1'b0);
        tick();
        smp();
        check("t3_c1_illegal", illegal, 1'b1);
        check("t3_c1_cmp_option", bif.cmp_option, 3'b000);
        tick();
        smp();
        check("t3_c2_br_done", bif.br_done, 1'b1);
        check("t3_c2_redirect", bif.redirect, 1'b0);
        tick();
        drive(1'b0, 3'b000, 32'h0, 1'b1, 1'b1);
        smp();
        check("t3_total_cnt", total_cnt, 2'd3);
        check("t3_illegal_sticky", illegal, 1'b1);

        // Idle clear of statistics.
        tick();
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        smp();
        check("clr_total_cnt", total_cnt, 2'd0);
        check("clr_taken_cnt", taken_cnt, 2'd0);
        check("clr_illegal", illegal, 1'b0);

        // Operands never ready: four WAIT cycles then forced not-taken.
        tick();
        drive(1'b1, 3'b001, 32'h0000_5000, 1'b0, 1'b0);
        eq_val = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            smp();
            check($sformatf("t4_c%0d_cmp_option", i), bif.cmp_option, 3'b000);
            check($sformatf("t4_c%0d_br_done", i), bif.br_done, 1'b0);
        end
        check("t4_c4_timeout", timeout, 1'b0);
        tick();
        smp();
        check("t4_c5_br_done", bif.br_done, 1'b1);
        check("t4_c5_redirect", bif.redirect, 1'b0);
        check("t4_c5_timeout", timeout, 1'b1);
        check("t4_c5_redirect_pc", bif.redirect_pc, 32'h0000_3010);
        tick();
        drive(1'b0, 3'b000, 32'h0, 1'b1, 1'b1);
        smp();
        check("t4_total_cnt", total_cnt, 2'd1);
        check("t4_taken_cnt", taken_cnt, 2'd0);

        // Flush in EVAL: request withdrawn, nothing retires.
        tick();
        drive(1'b1, 3'b111, 32'h0000_7000, 1'b1, 1'b1);
        tick();
        bif.br_req = 1'b0;
        smp();
        check("t5_c1_cmp_option", bif.cmp_option, 3'b111);
        check("t5_c1_stall", bif.stall, 1'b0);
        tick();
        smp();
        check("t5_c2_br_done", bif.br_done, 1'b0);
        check("t5_c2_cmp_option", bif.cmp_option, 3'b000);
        tick();
        smp();
        check("t5_c3_br_done", bif.br_done, 1'b0);
        check("t5_total_cnt", total_cnt, 2'd1);
        check("t5_taken_cnt", taken_cnt, 2'd0);
        check("t5_redirect_pc", bif.redirect_pc, 32'h0000_3010);

        // Five always-taken branches saturate both 2-bit counters.
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(1'b1, 3'b111, 32'h0000_8000 + 32'(i * 4), 1'b1, 1'b1);
            tick();
            tick();
            smp();
            check($sformatf("t6_b%0d_redirect", i), bif.redirect, 1'b1);
            tick();
            bif.br_req = 1'b0;
        end
        smp();
        check("t6_total_sat", total_cnt, 2'd3);
        check("t6_taken_sat", taken_cnt, 2'd3);
        check("t6_redirect_pc", bif.redirect_pc, 32'h0000_8010);

        // Clear coinciding with DONE wins over the increment.
        tick();
        drive(1'b1, 3'b111, 32'h0000_9000, 1'b1, 1'b1);
        tick();
        tick();
        clr_stat = 1'b1;
        smp();
        check("t7_c2_br_done", bif.br_done, 1'b1);
        tick();
        clr_stat = 1'b0;
        bif.br_req = 1'b0;
        smp();
        check("t7_total_cnt", total_cnt, 2'd0);
        check("t7_taken_cnt", taken_cnt, 2'd0);
        check("t7_timeout", timeout, 1'b0);
        check("t7_redirect_pc", bif.redirect_pc, 32'h0000_9000);

        // Asynchronous reset in the middle of WAIT.
        tick();
        drive(1'b1, 3'b001, 32'h0000_a000, 1'b0, 1'b0);
        tick();
        tick();
        smp();
        check("t8_wait_stall", bif.stall, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_rst_redirect_pc", bif.redirect_pc, 32'h0);
        check("t8_rst_cmp_option", bif.cmp_option, 3'b000);
        check("t8_rst_br_done", bif.br_done, 1'b0);
        check("t8_rst_redirect", bif.redirect, 1'b0);
        check("t8_rst_stall", bif.stall, 1'b0);
        check("t8_rst_cnts", {taken_cnt, total_cnt}, 4'h0);
        tick();
        rst_n = 1'b1;
        // Not-ready op 111 goes straight to EVAL only if the state is IDLE.
        drive(1'b1, 3'b111, 32'h0000_b000, 1'b0, 1'b0);
        smp();
        check("t8_c0_cmp_option", bif.cmp_option, 3'b000);
        tick();
        smp();
        check("t8_c1_cmp_option", bif.cmp_option, 3'b111);
        tick();
        smp();
        check("t8_c2_br_done", bif.br_done, 1'b1);
        check("t8_c2_redirect_pc", bif.redirect_pc, 32'h0000_b000);
        tick();
        bif.br_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_seq.md
# branch_seq

Branch resolution sequencer for the ID stage of the five-stage MIPS pipeline. It accepts a compare request from decode, stalls the front end until source operands are forwarded-ready, drives the option code of the shared branch comparator, and samples its result. It then issues a registered one-cycle redirect with the branch target. It also keeps saturating branch statistics and sticky error flags for the debug interface.

## Interface
- `CNT_W`, 16: width of the statistics counters.
- `MAX_WAIT`, 8: maximum WAIT-state cycles before a forced not-taken resolution (must be ≥1).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `br_req`  in  1  decode holds a branch/jump compare instruction; held until `br_done` or flush.
- `br_op`  in  3  compare option: 000 never, 001 equal, 111 always, 010–110 reserved.
- `br_target`  in  32  branch target PC.
- `rs_ready`, `rt_ready`  in  1 each  forwarding unit reports operand valid.
- `cmp_res`  in  1  comparator result (combinational from `cmp_option`).
- `clr_stat`  in  1  synchronous clear of counters and sticky flags.
- `cmp_option`  out  3  option code to the comparator (registered).
- `stall`  out  1  freeze PC and IF/ID register (combinational).
- `br_done`  out  1  one-cycle completion pulse.
- `redirect`  out  1  taken; PC must load `redirect_pc` this cycle.
- `redirect_pc`  out  32  target of the last taken branch.
- `taken_cnt`, `total_cnt`  out  CNT_W each  saturating statistics.
- `illegal`, `timeout`  out  1 each  sticky error flags.

## Operation
- States: IDLE, WAIT, EVAL, DONE. Reset: IDLE. All registered outputs are 0 in reset, including counters, flags, `redirect_pc` and `cmp_option`.
- IDLE: `cmp_option`=000. On `br_req`, latch `br_op` and `br_target`.
  - Op 001 with `rs_ready&rt_ready`=0 → WAIT, wait counter cleared.
  - Otherwise → EVAL.
  - Reserved op: set `illegal`, latch it as 000 (never taken); reserved codes are never driven to the comparator.
- WAIT: `cmp_option`=000.
  - Both ready → EVAL.
  - Not ready and wait counter = MAX_WAIT−1 → DONE, resolved not-taken, set `timeout`.
  - Otherwise increment the wait counter.
- EVAL: `cmp_option`=latched op. Sample `cmp_res` at the closing edge → DONE.
- DONE: `br_done`=1, `redirect`=sampled result, then → IDLE unconditionally.
  - `redirect_pc` loads the target only when taken; otherwise it holds.
  - `total_cnt`+1, and `taken_cnt`+1 if taken. Both saturate at all-ones.
- Flush: `br_req`=0 in WAIT or EVAL aborts to IDLE. No `br_done`, no counter or flag update (`illegal` already set stays set).
- `clr_stat` zeroes counters, `illegal` and `timeout`. It wins over a same-cycle increment or flag set.
- `stall` = `br_req` & (state ≠ DONE).

## Timing
- Request at cycle 0 with operands ready: EVAL in cycle 1, DONE (`br_done`, `redirect`) in cycle 2.
- `stall` is high in cycles 0–1 and low in cycle 2, so the pipeline advances on the DONE edge.
- Each WAIT cycle adds one cycle of latency. Worst case: `br_done` at cycle MAX_WAIT+1.
- Back-to-back requests: a new request is accepted only in IDLE, giving a minimum of 3 cycles per branch.
- `cmp_option` changes only on clock edges. `cmp_res` is sampled only in EVAL.
- `rst_n` low at any point forces IDLE and zeroes outputs immediately, with no `br_done`.

## Test plan
- Op 001, both ready, `cmp_res`=1, target 0x00003010, request at cycle 0 -> `cmp_option`=001 in cycle 1; `br_done`=`redirect`=1 and `redirect_pc`=0x00003010 in cycle 2; `stall` 1,1,0; `taken_cnt`=`total_cnt`=1.
- Op 001, `rt_ready` low in cycles 0–2 and high from cycle 3, `cmp_res`=0 -> `cmp_option`=000 in cycles 1–3, 001 in cycle 4; `br_done` in cycle 5 with `redirect`=0; `redirect_pc` unchanged; `total_cnt`=1, `taken_cnt`=0.
- MAX_WAIT=4, op 001, operands never ready -> WAIT in cycles 1–4, `cmp_option` never 001; `br_done` in cycle 5 with `redirect`=0; `timeout`=1.
- Op 011 -> `illegal`=1 from cycle 1, `cmp_option`=000 in cycle 1, `br_done` with `redirect`=0 in cycle 2, `total_cnt`+1.
- CNT_W=2, five op-111 branches -> `taken_cnt`=`total_cnt`=3 (saturated). Then `clr_stat` in the same cycle as the next DONE -> both read 0 afterwards.
- `br_req` dropped in EVAL -> back to IDLE, no `br_done`, counters unchanged. `rst_n` pulsed low mid-WAIT -> all outputs 0 asynchronously, state IDLE.
